// File: rtl/uart_tx_wb_if.sv
// Wishbone classic bus bundle for an 8-bit device.
// Signal names are taken from the device's point of view.
interface wishbone_classic;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       stall_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    input  dat_o, ack_o, stall_o
  );

  modport device (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o, stall_o
  );

  // Same view as device, for callers that use master/slave naming.
  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o, stall_o
  );
endinterface

// File: rtl/uart_tx_wb.sv
// Wishbone classic UART transmitter, 8N1 (or 8N2), LSB first.
// The bus stalls for the whole frame; each accepted request is acked
// on the following cycle. Reads are acked with zero data and send nothing.
module uart_tx_wb #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wishbone_classic.device wb,
  output logic      tx_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shift, shift_nx;
  logic             tx_nx;
  logic             ack;

  logic req, accept, wr_accept, baud_done;

  assign req       = wb.cyc_i && wb.stb_i;
  assign accept    = req && !wb.stall_o;
  assign wr_accept = accept && wb.we_i;
  assign baud_done = (baud_cnt == BAUD_LAST);

  assign wb.stall_o = (state != IDLE);
  assign wb.ack_o   = ack;
  assign wb.dat_o   = 8'h00;

  // State, counters, shift register, registered line and ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
      ack      <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      tx_o     <= tx_nx;
      ack      <= accept;
    end
  end

  // Next-state: walk START -> DATA x8 -> STOP xSTOP_BITS, one bit period each.
  // bit_idx is reused to count stop bits; it is 0 on entry to every state.
  always_comb begin
    state_nx = state;
    baud_nx  = baud_done ? '0 : baud_cnt + CNT_W'(1);
    bit_nx   = bit_idx;
    shift_nx = shift;
    unique case (state)
      IDLE: begin
        baud_nx = '0;
        bit_nx  = '0;
        if (wr_accept) begin
          shift_nx = wb.dat_i;
          state_nx = START;
        end
      end
      START: begin
        if (baud_done) state_nx = DATA;
      end
      DATA: begin
        if (baud_done) begin
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_nx   = '0;
            state_nx = STOP;
          end else begin
            bit_nx = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (bit_idx == STOP_LAST) begin
            bit_nx   = '0;
            state_nx = IDLE;
          end else begin
            bit_nx = bit_idx + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level for the next cycle, derived from where the FSM is going,
  // so tx_o is a clean flop output aligned with the state.
  always_comb begin
    tx_nx = 1'b1;
    if (state_nx == START)     tx_nx = 1'b0;
    else if (state_nx == DATA) tx_nx = shift_nx[0];
  end

endmodule
